// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 binary32 multiplier with tag pass-through and per-result flags.
// Optional sticky flag accumulator enabled by defining FMUL_STICKY_FLAGS_EN.
module fmul_pipe #(
  parameter int STAGES = 2,
  parameter int TAG_W  = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_s,
  input  logic [31:0]      in_t,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_d,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             out_udf,
  output logic             out_inv
`ifdef FMUL_STICKY_FLAGS_EN
  ,
  input  logic             flag_clr,
  output logic [2:0]       flags_acc
`endif
);

  // Handshake: an op transfers on in_valid & in_ready, a result is consumed on
  // out_valid & out_ready; while out_valid & ~out_ready every stage holds.
  typedef struct packed {
    logic              sgn;
    logic signed [9:0] exp;
    logic [47:0]       prod;
    logic              spec;
    logic [31:0]       spec_d;
    logic              spec_inv;
    logic [TAG_W-1:0]  tag;
  } mid_t;

  localparam int LAST = STAGES - 2;

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  logic [7:0]  es, et;
  logic [22:0] ms, mt;
  logic        s_nan, t_nan, s_inf, t_inf, s_zero, t_zero, sgn;
  logic [47:0] prod;
  mid_t        s1;

  assign es     = in_s[30:23];
  assign et     = in_t[30:23];
  assign ms     = in_s[22:0];
  assign mt     = in_t[22:0];
  assign s_nan  = (es == 8'hFF) && (ms != 23'd0);
  assign t_nan  = (et == 8'hFF) && (mt != 23'd0);
  assign s_inf  = (es == 8'hFF) && (ms == 23'd0);
  assign t_inf  = (et == 8'hFF) && (mt == 23'd0);
  // Exponent 0 covers subnormals too: they flush to zero silently.
  assign s_zero = (es == 8'd0);
  assign t_zero = (et == 8'd0);
  assign sgn    = in_s[31] ^ in_t[31];
  assign prod   = {1'b1, ms} * {1'b1, mt};

  always_comb begin
    s1          = '0;
    s1.sgn      = sgn;
    s1.tag      = in_tag;
    s1.prod     = prod;
    s1.exp      = $signed({2'b00, es}) + $signed({2'b00, et}) - 10'sd127;
    if (s_nan) begin
      s1.spec     = 1'b1;
      s1.spec_d   = in_s | 32'h0040_0000;
      s1.spec_inv = ~in_s[22];
    end else if (t_nan) begin
      s1.spec     = 1'b1;
      s1.spec_d   = in_t | 32'h0040_0000;
      s1.spec_inv = ~in_t[22];
    end else if ((s_inf && t_zero) || (s_zero && t_inf)) begin
      s1.spec     = 1'b1;
      s1.spec_d   = 32'h7FC0_0000;
      s1.spec_inv = 1'b1;
    end else if (s_inf || t_inf) begin
      s1.spec   = 1'b1;
      s1.spec_d = {sgn, 8'hFF, 23'd0};
    end else if (s_zero || t_zero) begin
      s1.spec   = 1'b1;
      s1.spec_d = {sgn, 31'd0};
    end
  end

  mid_t mid_q [0:LAST];
  logic mid_v [0:LAST];

  // Stage 0 captures the product; further entries are plain delay registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i <= LAST; i++) begin
        mid_v[i] <= 1'b0;
        mid_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i <= LAST; i++) mid_v[i] <= 1'b0;
    end else if (!stall) begin
      mid_v[0] <= in_valid;
      mid_q[0] <= s1;
      for (int i = 1; i <= LAST; i++) begin
        mid_v[i] <= mid_v[i-1];
        mid_q[i] <= mid_q[i-1];
      end
    end
  end

  mid_t              fq;
  logic              carry, g, rs, round_up;
  logic [22:0]       mant;
  logic [23:0]       mant_r;
  logic signed [9:0] e1;
  logic [31:0]       res_d;
  logic              res_ovf, res_udf, res_inv;

  assign fq    = mid_q[LAST];
  assign carry = fq.prod[47];

  always_comb begin
    if (carry) begin
      mant = fq.prod[46:24];
      g    = fq.prod[23];
      rs   = |fq.prod[22:0];
    end else begin
      mant = fq.prod[45:23];
      g    = fq.prod[22];
      rs   = |fq.prod[21:0];
    end
    round_up = g & (rs | mant[0]);
    // A round-up overflowing the mantissa leaves zeros in [22:0] and bumps e.
    mant_r   = {1'b0, mant} + {23'd0, round_up};
    e1       = fq.exp + $signed({9'd0, carry}) + $signed({9'd0, mant_r[23]});
    res_d    = {fq.sgn, e1[7:0], mant_r[22:0]};
    res_ovf  = 1'b0;
    res_udf  = 1'b0;
    res_inv  = 1'b0;
    if (fq.spec) begin
      res_d   = fq.spec_d;
      res_inv = fq.spec_inv;
    end else if (e1 >= 10'sd255) begin
      res_d   = {fq.sgn, 8'hFF, 23'd0};
      res_ovf = 1'b1;
    end else if (e1 <= 10'sd0) begin
      res_d   = {fq.sgn, 31'd0};
      res_udf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_d     <= '0;
      out_tag   <= '0;
      out_ovf   <= 1'b0;
      out_udf   <= 1'b0;
      out_inv   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_d     <= '0;
      out_tag   <= '0;
      out_ovf   <= 1'b0;
      out_udf   <= 1'b0;
      out_inv   <= 1'b0;
    end else if (!stall) begin
      out_valid <= mid_v[LAST];
      out_d     <= mid_v[LAST] ? res_d : 32'd0;
      out_tag   <= mid_v[LAST] ? fq.tag : '0;
      out_ovf   <= mid_v[LAST] & res_ovf;
      out_udf   <= mid_v[LAST] & res_udf;
      out_inv   <= mid_v[LAST] & res_inv;
    end
  end

`ifdef FMUL_STICKY_FLAGS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       flags_acc <= 3'd0;
    else if (flag_clr)               flags_acc <= 3'd0;
    else if (out_valid && out_ready) flags_acc <= flags_acc | {out_inv, out_ovf, out_udf};
  end
`endif

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe: directed vectors, stall, flush and reset checks.
module tb_fmul_pipe;
  localparam int STAGES = 2;
  localparam int TAG_W  = 6;
  localparam int W      = 32 + TAG_W + 3;

  logic             clk = 1'b0;
  logic             rstn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_s, in_t, out_d;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             out_ovf, out_udf, out_inv;
`ifdef FMUL_STICKY_FLAGS_EN
  logic             flag_clr;
  logic [2:0]       flags_acc;
`endif

  fmul_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_t(in_t), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_tag(out_tag),
    .out_ovf(out_ovf), .out_udf(out_udf), .out_inv(out_inv)
`ifdef FMUL_STICKY_FLAGS_EN
    , .flag_clr(flag_clr), .flags_acc(flags_acc)
`endif
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // ---- scoreboard ----
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  bit           lat_chk = 1'b0;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---- driver tasks (called at posedge+#1) ----
  task automatic send(input logic [31:0] s, input logic [31:0] t, input logic [TAG_W-1:0] tag,
                      input logic [31:0] d, input logic [2:0] f);
    int waited = 0;
    in_s = s; in_t = t; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    else begin
      exp_q.push_back({d, tag, f});
      acc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // ---- monitor ----
  logic             stalled_p = 1'b0;
  logic             flush_p = 1'b0;
  logic [31:0]      d_p;
  logic [TAG_W-1:0] tag_p;

  initial begin
    logic [W-1:0] e;
    int           a;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stalled_p = 1'b0;
        flush_p   = 1'b0;
        continue;
      end
      if (stalled_p && !flush_p) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_d", 64'(out_d), 64'(d_p));
        check("hold_tag", 64'(out_tag), 64'(tag_p));
      end
      if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("result", 64'({out_d, out_tag, out_inv, out_ovf, out_udf}), 64'(e));
          if (lat_chk) check("latency", 64'(cyc - a), 64'(STAGES));
        end
      end
      stalled_p = out_valid && !out_ready;
      flush_p   = flush;
      d_p       = out_d;
      tag_p     = out_tag;
    end
  end

  // ---- stimulus ----
  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_s = '0; in_t = '0; in_tag = '0;
`ifdef FMUL_STICKY_FLAGS_EN
    flag_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_d", 64'(out_d), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_flags", 64'({out_inv, out_ovf, out_udf}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rstn = 1'b1; out_ready = 1'b1; lat_chk = 1'b1;
    @(posedge clk); #1;

    // flags argument is {inv, ovf, udf}
    send(32'h3FC00000, 32'h40000000, 6'd5,  32'h40400000, 3'b000);
    send(32'h7F7FFFFF, 32'h40000000, 6'd6,  32'h7F800000, 3'b010);
    send(32'h00800000, 32'h3F000000, 6'd7,  32'h00000000, 3'b001);
    send(32'h7F800000, 32'h80000000, 6'd8,  32'h7FC00000, 3'b100);
    send(32'h7F800001, 32'h3F800000, 6'd9,  32'h7FC00001, 3'b100);
    send(32'h3F800001, 32'h3F800001, 6'd10, 32'h3F800002, 3'b000);
    send(32'h3FFFFFFF, 32'h3FFFFFFF, 6'd11, 32'h407FFFFE, 3'b000);
    send(32'hC0000000, 32'h40400000, 6'd12, 32'hC0C00000, 3'b000);
    send(32'hFF800000, 32'h40000000, 6'd13, 32'hFF800000, 3'b000);
    send(32'h80000000, 32'h3F800000, 6'd14, 32'h80000000, 3'b000);
    send(32'h00400000, 32'h7F000000, 6'd15, 32'h00000000, 3'b000);
    send(32'h7FC00000, 32'h7F800001, 6'd16, 32'h7FC00000, 3'b000);
    send(32'h3F800000, 32'h7F800001, 6'd17, 32'h7FC00001, 3'b100);
    send(32'h00000000, 32'hFF800000, 6'd18, 32'h7FC00000, 3'b100);
    send(32'h3F800001, 32'h3FFFFFFE, 6'd19, 32'h40000000, 3'b000);
    send(32'h7F7FFFFF, 32'h3F800001, 6'd20, 32'h7F800000, 3'b010);
    send(32'h3F800001, 32'h3FC00000, 6'd21, 32'h3FC00002, 3'b000);
    send(32'h3F800003, 32'h3FC00000, 6'd22, 32'h3FC00004, 3'b000);
    drain();

`ifdef FMUL_STICKY_FLAGS_EN
    check("flags_acc_set", 64'(flags_acc), 64'd7);
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    check("flags_acc_clr", 64'(flags_acc), 64'd0);
`endif

    // back-to-back stream with a 3-cycle consumer stall
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(32'h40000000 + 32'(i), 32'h3F800000, TAG_W'(i), 32'h40000000 + 32'(i), 3'b000);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // flush with ops in flight while the consumer is stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_s = 32'h3F800000; in_t = 32'h40000000; in_tag = TAG_W'(40 + i);
      @(posedge clk); #1;
    end
    flush = 1'b1; in_tag = 6'd50;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < STAGES + 2; i++) begin
      @(negedge clk);
      check("flush_no_out", 64'(out_valid), 64'd0);
    end

    // reset pulse mid-stream
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_s = 32'h40000000; in_t = 32'h40000000; in_tag = TAG_W'(60 + i);
      @(posedge clk); #1;
    end
    #2 rstn = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_out_d", 64'(out_d), 64'd0);
    check("rst2_out_tag", 64'(out_tag), 64'd0);
    check("rst2_flags", 64'({out_inv, out_ovf, out_udf}), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < STAGES + 2; i++) begin
      @(negedge clk);
      check("rst2_no_out", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    lat_chk = 1'b1;
    send(32'h3FC00000, 32'h40000000, 6'd5, 32'h40400000, 3'b000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
